conditional_logic_pipe: RTL
===========================

Name: conditional_logic_pipe

Overview:
Parametrised next-generation ARM conditional-execution unit for the calculator datapath. It holds the NZCV flag register, which now supports split NZ/CV write enables. It evaluates all 16 condition codes against that register and gates the PC, register-file and memory write strobes. It adds an optional output pipeline register, a selectable output polarity, an instruction-valid qualifier and saturating executed/squashed instruction counters for debug.

Parameters:
ACTIVE_LOW, 1, 1 = PCSrc/RegWrite/MemWrite are negative logic (inactive level 1); 0 = positive logic
OUT_REG, 0, 0 = strobes and CondExOut are combinational; 1 = registered, one-cycle latency
CNT_W, 16, width of ExecCount and SquashCount

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  synchronous active-high reset
Valid  input  1  current instruction is real; 0 = bubble
Cond  input  4  instruction condition field
ALUFlags  input  4  {N,Z,C,V} from ALU for current instruction
FlagW  input  2  bit1 = write N,Z; bit0 = write C,V
PCS  input  1  instruction writes PC
RegW  input  1  instruction writes register file
MemW  input  1  instruction writes memory
NoWrite  input  1  suppress register write (CMP/CMN/TST/TEQ)
CntClr  input  1  synchronous clear of both counters
PCSrc  output  1  PC source select, polarity per ACTIVE_LOW
RegWrite  output  1  register-file write enable, polarity per ACTIVE_LOW
MemWrite  output  1  memory write enable, polarity per ACTIVE_LOW
CondExOut  output  1  condition passed, always active-high
Flags  output  4  current flag register {N,Z,C,V}
ExecCount  output  CNT_W  count of valid instructions whose condition passed
SquashCount  output  CNT_W  count of valid instructions whose condition failed

Behaviour:
- Clock is CLK. Reset RST is synchronous and active-high.
- Reset: Flags=0000. Both counters = 0. Output registers (OUT_REG=1) go to the inactive level: 1 when ACTIVE_LOW=1, 0 otherwise. CondExOut=0.
- While RST=1 in either mode: strobes are forced inactive, CondExOut=0, and no flag or counter update occurs. Reset asserted mid-instruction discards that instruction.
- Condition evaluation uses the registered Flags, i.e. the state before the current instruction. Codes:
  - 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V
  - 8 HI C&~Z; 9 LS ~C|Z; A GE N==V; B LT N!=V; C GT ~Z&(N==V); D LE Z|(N!=V)
  - E AL 1; F 1 (treated as always)
- CondEx = Valid & cond_true.
- Internal strobes:
  - pcs_i = PCS & CondEx
  - regw_i = RegW & CondEx & ~NoWrite
  - memw_i = MemW & CondEx
  - Each is inverted at the output when ACTIVE_LOW=1.
- OUT_REG=0: strobes and CondExOut are combinational from the current inputs. OUT_REG=1: they are registered and appear the cycle after the instruction is presented.
- Flag update at posedge when CondEx=1 and RST=0:
  - FlagW[1] loads Flags[3:2] <= ALUFlags[3:2]
  - FlagW[0] loads Flags[1:0] <= ALUFlags[1:0]
  - A field not enabled holds its value.
  - The updated flags are visible to the next instruction's evaluation, independent of OUT_REG.
- Counters at posedge:
  - CntClr has priority and clears both counters.
  - Otherwise Valid&CondEx increments ExecCount; Valid&~CondEx increments SquashCount.
  - Both counters saturate at 2^CNT_W-1 (no wrap).
  - Valid=0 changes neither counter.
- Back-to-back instructions are allowed every cycle; there are no stalls.

Test Plan:
- RST high for 2 cycles, ACTIVE_LOW=1 -> Flags=0000, counters 0, PCSrc=RegWrite=MemWrite=1, CondExOut=0.
- From Flags=0000: Cond=E, FlagW=11, ALUFlags=0100, RegW=1 -> RegWrite=0 (active) that cycle, Flags=0100 next cycle. Then Cond=0 (EQ), MemW=1 -> MemWrite=0, ExecCount=2.
- Flags=0100: Cond=1 (NE), PCS=1, FlagW=11, ALUFlags=1111 -> strobes inactive, Flags unchanged at 0100, SquashCount increments.
- Split write: Flags=0000, Cond=E, FlagW=01, ALUFlags=1111 -> Flags=0011. Then FlagW=10, ALUFlags=1000 -> Flags=1011. Then Cond=A (GE) with N=1,V=1 passes and Cond=C (GT) passes.
- OUT_REG=1, ACTIVE_LOW=0: Cond=E, RegW=1, NoWrite=0 at cycle t -> RegWrite=1 at t+1 only. NoWrite=1 -> RegWrite stays 0 but ExecCount increments. Valid=0 -> no counter change.
- CNT_W=3: apply 9 passing instructions -> ExecCount stops at 7. CntClr together with a passing instruction -> ExecCount=0 next cycle.

Source files
------------

// File: rtl/conditional_logic_pipe_if.sv
// Instruction/strobe bundle between the decoder and the conditional-execution unit.
// master drives the instruction fields; slave is the conditional_logic_pipe itself.
interface conditional_logic_pipe_if #(
    parameter int CNT_W = 16
);
    logic             Valid;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS;
    logic             RegW;
    logic             MemW;
    logic             NoWrite;
    logic             CntClr;
    logic             PCSrc;
    logic             RegWrite;
    logic             MemWrite;
    logic             CondExOut;
    logic [3:0]       Flags;
    logic [CNT_W-1:0] ExecCount;
    logic [CNT_W-1:0] SquashCount;

    modport master (
        output Valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, CntClr,
        input  PCSrc, RegWrite, MemWrite, CondExOut, Flags, ExecCount, SquashCount
    );

    modport slave (
        input  Valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, CntClr,
        output PCSrc, RegWrite, MemWrite, CondExOut, Flags, ExecCount, SquashCount
    );
endinterface

// File: rtl/conditional_logic_pipe.sv
// ARM-style conditional-execution unit: NZCV register with split write enables,
// 16-code condition check, gated write strobes and saturating debug counters.
module conditional_logic_pipe #(
    parameter int ACTIVE_LOW = 1,
    parameter int OUT_REG    = 0,
    parameter int CNT_W      = 16
) (
    input logic                  CLK,
    input logic                  RST,
    conditional_logic_pipe_if.slave bus
);
    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
    } cond_e;

    localparam logic             INACTIVE = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
    logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;
    logic             n, z, c, v;
    logic             cond_true;
    logic             cond_ex;
    logic             squash;
    logic [2:0]       strobe_d;

    assign {n, z, c, v} = flags_q;

    always_comb begin
        // NOTE: default first so every path assigns cond_true and no latch is inferred.
        cond_true = 1'b1;
        case (cond_e'(bus.Cond))
            COND_EQ: cond_true = z;
            COND_NE: cond_true = ~z;
            COND_CS: cond_true = c;
            COND_CC: cond_true = ~c;
            COND_MI: cond_true = n;
            COND_PL: cond_true = ~n;
            COND_VS: cond_true = v;
            COND_VC: cond_true = ~v;
            COND_HI: cond_true = c & ~z;
            COND_LS: cond_true = ~c | z;
            COND_GE: cond_true = (n == v);
            COND_LT: cond_true = (n != v);
            COND_GT: cond_true = ~z & (n == v);
            COND_LE: cond_true = z | (n != v);
            COND_AL, COND_NV: cond_true = 1'b1;
        endcase
    end

    // Reset squashes the instruction in flight, including the combinational strobes.
    assign cond_ex  = bus.Valid & cond_true & ~RST;
    assign squash   = bus.Valid & ~cond_true;
    assign strobe_d = {bus.PCS & cond_ex,
                       bus.RegW & cond_ex & ~bus.NoWrite,
                       bus.MemW & cond_ex} ^ {3{INACTIVE}};

    always_comb begin
        flags_d      = flags_q;
        exec_cnt_d   = exec_cnt_q;
        squash_cnt_d = squash_cnt_q;
        if (cond_ex) begin
            if (bus.FlagW[1]) flags_d[3:2] = bus.ALUFlags[3:2];
            if (bus.FlagW[0]) flags_d[1:0] = bus.ALUFlags[1:0];
        end
        if (bus.CntClr) begin
            exec_cnt_d   = '0;
            squash_cnt_d = '0;
        end else begin
            if (cond_ex && exec_cnt_q != CNT_MAX)  exec_cnt_d   = exec_cnt_q + CNT_ONE;
            if (squash && squash_cnt_q != CNT_MAX) squash_cnt_d = squash_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: RST is synchronous, so it only takes effect on a rising CLK edge.
        if (RST) begin
            // NOTE: non-blocking assignments keep all flops sampling pre-edge values.
            flags_q      <= '0;
            exec_cnt_q   <= '0;
            squash_cnt_q <= '0;
        end else begin
            flags_q      <= flags_d;
            exec_cnt_q   <= exec_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [2:0] strobe_q;
            logic       cond_out_q;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    strobe_q   <= {3{INACTIVE}};
                    cond_out_q <= 1'b0;
                end else begin
                    strobe_q   <= strobe_d;
                    cond_out_q <= cond_ex;
                end
            end

            assign {bus.PCSrc, bus.RegWrite, bus.MemWrite} = strobe_q;
            assign bus.CondExOut = cond_out_q;
        end else begin : g_out_comb
            assign {bus.PCSrc, bus.RegWrite, bus.MemWrite} = strobe_d;
            assign bus.CondExOut = cond_ex;
        end
    endgenerate

    assign bus.Flags       = flags_q;
    assign bus.ExecCount   = exec_cnt_q;
    assign bus.SquashCount = squash_cnt_q;
endmodule
